// File: rtl/pri_req_latch.sv
// Request-capture stage ahead of the priority encoder: synchronizes raw request
// lines, latches rising edges as sticky pending bits and serves the highest one.
module pri_req_latch #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] req_in,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] pending,
    output logic [IDX_W:0]   pending_cnt,
    output logic [WIDTH-1:0] overrun
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] take;

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    function automatic logic [IDX_W-1:0] top_index(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [IDX_W:0] pop_count(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + (IDX_W+1)'(v[i]);
        end
        return cnt;
    endfunction

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= req_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise        = s2 & ~s3;
    assign out_idx     = top_index(pending);
    assign out_valid   = enable & (|pending);
    assign pending_cnt = pop_count(pending);

    always_comb begin
        take = '0;
        for (int i = 0; i < WIDTH; i++) begin
            take[i] = out_valid & out_ready & (out_idx == IDX_W'(i));
        end
    end

    // A fresh edge coinciding with acceptance re-arms the bit and is not an overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= rise | (pending & ~take);
            overrun <= (rise & pending & ~take) | (overrun & ~{WIDTH{clr_overrun}});
        end
    end

endmodule

// File: tb/tb_pri_req_latch.sv
// Self-checking bench for pri_req_latch: directed scenarios followed by random
// traffic, compared against a per-line behavioural model.
module tb_pri_req_latch;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] req_in;
    logic        out_ready;
    logic        clr_overrun;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic [15:0] pending;
    logic [4:0]  pending_cnt;
    logic [15:0] overrun;

    int checks = 0;
    int errors = 0;

    // Model: per-line request state and the history of sampled input words.
    int          pend_m[16];
    int          ovr_m[16];
    logic [15:0] hist[$];

    pri_req_latch #(.WIDTH(16), .IDX_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .req_in     (req_in),
        .out_ready  (out_ready),
        .clr_overrun(clr_overrun),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .pending    (pending),
        .pending_cnt(pending_cnt),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_top();
        int sel;
        sel = 0;
        for (int i = 0; i < 16; i++) if (pend_m[i] != 0) sel = i;
        return sel;
    endfunction

    function automatic int model_count();
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) n += pend_m[i];
        return n;
    endfunction

    task automatic check_all(input string tag);
        logic [15:0] pv;
        logic [15:0] ov;
        int n;
        pv = '0;
        ov = '0;
        for (int i = 0; i < 16; i++) begin
            pv[i] = (pend_m[i] != 0);
            ov[i] = (ovr_m[i] != 0);
        end
        n = model_count();
        chk({tag, ".valid"},   32'(out_valid),   32'(enable && n > 0));
        chk({tag, ".idx"},     32'(out_idx),     32'(model_top()));
        chk({tag, ".pending"}, 32'(pending),     32'(pv));
        chk({tag, ".cnt"},     32'(pending_cnt), 32'(n));
        chk({tag, ".overrun"}, 32'(overrun),     32'(ov));
    endtask

    // One clock edge: advance the model from the pre-edge inputs, then compare.
    task automatic tick(input string tag);
        int  new_p[16];
        int  new_o[16];
        int  sel;
        bit  v;
        bit  r;
        bit  t;
        v   = enable && (model_count() > 0);
        sel = model_top();
        for (int i = 0; i < 16; i++) begin
            r = hist[1][i] && !hist[2][i];
            t = v && out_ready && (sel == i);
            new_p[i] = (r || (pend_m[i] != 0 && !t)) ? 1 : 0;
            new_o[i] = ((r && pend_m[i] != 0 && !t) || (ovr_m[i] != 0 && !clr_overrun)) ? 1 : 0;
        end
        hist.push_front(req_in);
        void'(hist.pop_back());
        @(posedge clock);
        #1;
        for (int i = 0; i < 16; i++) begin
            pend_m[i] = new_p[i];
            ovr_m[i]  = new_o[i];
        end
        check_all(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        hist.delete();
        for (int k = 0; k < 3; k++) hist.push_back(16'h0);
        for (int i = 0; i < 16; i++) begin
            pend_m[i] = 0;
            ovr_m[i]  = 0;
        end
        check_all({tag, ".in_reset"});
        chk({tag, ".valid0"}, 32'(out_valid), 32'h0);
        chk({tag, ".idx0"},   32'(out_idx),   32'h0);
        chk({tag, ".cnt0"},   32'(pending_cnt), 32'h0);
        @(posedge clock);
        #1;
        check_all({tag, ".held"});
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        req_in      = 16'h0;
        out_ready   = 1'b0;
        clr_overrun = 1'b0;

        // Idle after reset
        do_reset("rst");
        ticks(10, "idle");
        chk("idle.pending", 32'(pending), 32'h0);
        chk("idle.overrun", 32'(overrun), 32'h0);

        // Single request on line 5, exact three-edge latency
        req_in = 16'h0020;
        ticks(2, "r5");
        chk("r5.early", 32'(pending), 32'h0);
        tick("r5");
        chk("r5.pending", 32'(pending), 32'h0020);
        chk("r5.idx", 32'(out_idx), 32'd5);
        chk("r5.cnt", 32'(pending_cnt), 32'd1);
        out_ready = 1'b1;
        tick("r5.take");
        out_ready = 1'b0;
        chk("r5.cleared", 32'(pending), 32'h0);
        chk("r5.novalid", 32'(out_valid), 32'h0);
        ticks(2, "r5.hold");
        req_in = 16'h0;
        ticks(3, "r5.low");

        // Three simultaneous requests served back-to-back, highest first
        out_ready = 1'b1;
        req_in = 16'h4208;
        ticks(3, "multi");
        chk("multi.idx14", 32'(out_idx), 32'd14);
        chk("multi.cnt3", 32'(pending_cnt), 32'd3);
        tick("multi");
        chk("multi.idx9", 32'(out_idx), 32'd9);
        chk("multi.cnt2", 32'(pending_cnt), 32'd2);
        tick("multi");
        chk("multi.idx3", 32'(out_idx), 32'd3);
        chk("multi.cnt1", 32'(pending_cnt), 32'd1);
        tick("multi");
        chk("multi.cnt0", 32'(pending_cnt), 32'd0);
        req_in = 16'h0;
        out_ready = 1'b0;
        ticks(3, "multi.low");

        // Overrun while disabled, then clear and serve
        enable = 1'b0;
        req_in = 16'h0080;
        ticks(3, "ovr");
        req_in = 16'h0;
        ticks(3, "ovr.low");
        req_in = 16'h0080;
        ticks(3, "ovr.again");
        chk("ovr.flag", 32'(overrun), 32'h0080);
        chk("ovr.pending", 32'(pending), 32'h0080);
        chk("ovr.novalid", 32'(out_valid), 32'h0);
        clr_overrun = 1'b1;
        tick("ovr.clr");
        clr_overrun = 1'b0;
        chk("ovr.cleared", 32'(overrun), 32'h0);
        enable = 1'b1;
        #1;
        chk("ovr.idx7", 32'(out_idx), 32'd7);
        chk("ovr.valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        tick("ovr.take");
        out_ready = 1'b0;
        req_in = 16'h0;
        ticks(3, "ovr.low2");

        // New edge on line 2 landing on the accepting cycle: set wins
        req_in = 16'h0004;
        ticks(3, "sw");
        req_in = 16'h0;
        ticks(3, "sw.low");
        req_in = 16'h0004;
        ticks(2, "sw.sync");
        out_ready = 1'b1;
        tick("sw.take");
        chk("sw.pending", 32'(pending), 32'h0004);
        chk("sw.overrun", 32'(overrun), 32'h0);
        chk("sw.idx", 32'(out_idx), 32'd2);
        tick("sw.take2");
        out_ready = 1'b0;
        chk("sw.cleared", 32'(pending), 32'h0);

        // All lines high, reset mid-stream, then recapture after release
        req_in = 16'hFFFF;
        out_ready = 1'b1;
        ticks(4, "all");
        out_ready = 1'b0;
        do_reset("midrst");
        chk("midrst.pending", 32'(pending), 32'h0);
        ticks(2, "all.post");
        chk("all.early", 32'(pending), 32'h0);
        tick("all.post");
        chk("all.pending", 32'(pending), 32'hFFFF);
        chk("all.cnt16", 32'(pending_cnt), 32'd16);
        out_ready = 1'b1;
        req_in = 16'h0;
        ticks(18, "drain");

        // Random traffic with levels held at least two cycles
        for (int seg = 0; seg < 60; seg++) begin
            req_in = 16'($urandom);
            for (int k = 0; k < int'($urandom_range(2, 5)); k++) begin
                enable      = ($urandom_range(0, 3) != 0);
                out_ready   = 1'($urandom_range(0, 1));
                clr_overrun = ($urandom_range(0, 7) == 0);
                tick("rnd");
            end
            if (seg == 30) begin
                clr_overrun = 1'b0;
                do_reset("rnd.rst");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
